// File: rtl/uart_img_pkg.sv
// -----------------------------------------------------------------------------
// uart_img_pkg
// Shared definitions for the UART image loader:
//   - rx_state_t      : receiver FSM state encoding
//   - calc_baud_cnt   : clock cycles per serial bit (integer division)
//   - calc_half       : cycles from start-bit edge to the middle of the start bit
//   - calc_addr_w     : pixel address width for a given image size
// Optional feature macro: UART_PARITY_EN adds the PARITY state (8E1 format).
// -----------------------------------------------------------------------------
package uart_img_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_t;

   function automatic int calc_baud_cnt(input int clk_hz, input int bps);
      return clk_hz / bps;
   endfunction

   function automatic int calc_half(input int baud_cnt);
      return baud_cnt / 2;
   endfunction

   // A one-pixel image still needs a 1-bit address port.
   function automatic int calc_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// Serial byte receiver: 2-flop synchronizer, start-bit detection, baud counter
// and framing FSM. Default format is 8N1; with UART_PARITY_EN defined an even
// parity bit follows the data bits (8E1).
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   uart_rxd   in   asynchronous serial line, idle high
//   busy       out  FSM is outside IDLE
//   byte_valid out  one-cycle pulse, rx_byte holds a freshly accepted byte
//   rx_byte    out  last accepted byte (held between pulses)
//   stop_err   out  one-cycle pulse, byte rejected for a low stop bit
//   parity_err out  one-cycle pulse, byte rejected for bad parity (0 if 8N1)
// -----------------------------------------------------------------------------
module uart_rx_byte
   import uart_img_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int UART_BPS = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic       busy,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       stop_err,
   output logic       parity_err
);

   localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, UART_BPS);
   localparam int HALF     = calc_half(BAUD_CNT);
   localparam int CNT_W    = $clog2(BAUD_CNT + 1);

   logic             rxd_s1, rxd_s2, rxd_prev;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             valid_q, stop_err_q;

   logic half_hit, baud_hit;
   logic cnt_clr, bit_clr, sample_data, accept, stop_fail;

`ifdef UART_PARITY_EN
   logic par_q, par_ok, sample_par, par_fail, par_err_q;
   // Even parity: data bits plus parity bit carry an even number of ones.
   assign par_ok = ((^shift_q) == par_q);
`endif

   assign half_hit = (cnt_q == CNT_W'(HALF - 1));
   assign baud_hit = (cnt_q == CNT_W'(BAUD_CNT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and per-cycle control
   always_comb begin
      state_d     = state_q;
      cnt_clr     = 1'b0;
      bit_clr     = 1'b0;
      sample_data = 1'b0;
      accept      = 1'b0;
      stop_fail   = 1'b0;
`ifdef UART_PARITY_EN
      sample_par  = 1'b0;
      par_fail    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            bit_clr = 1'b1;
            if (rxd_prev && !rxd_s2) state_d = ST_START;
         end
         ST_START: begin
            // A line that is high again at mid start bit was only a glitch.
            if (half_hit) begin
               cnt_clr = 1'b1;
               state_d = rxd_s2 ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_hit) begin
               cnt_clr     = 1'b1;
               sample_data = 1'b1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (baud_hit) begin
               cnt_clr    = 1'b1;
               sample_par = 1'b1;
               state_d    = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (baud_hit) begin
               cnt_clr = 1'b1;
               if (rxd_s2) begin
                  state_d = ST_IDLE;
`ifdef UART_PARITY_EN
                  if (par_ok) accept   = 1'b1;
                  else        par_fail = 1'b1;
`else
                  accept = 1'b1;
`endif
               end else begin
                  stop_fail = 1'b1;
                  state_d   = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // Wait out a held-low line so it is not mistaken for a start bit.
            cnt_clr = 1'b1;
            if (rxd_s2) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Synchronizer, counters and output strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_s1     <= 1'b1;
         rxd_s2     <= 1'b1;
         rxd_prev   <= 1'b1;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         valid_q    <= 1'b0;
         rx_byte    <= '0;
         stop_err_q <= 1'b0;
`ifdef UART_PARITY_EN
         par_err_q  <= 1'b0;
`endif
      end else begin
         rxd_s1     <= uart_rxd;
         rxd_s2     <= rxd_s1;
         rxd_prev   <= rxd_s2;
         cnt_q      <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
         if (bit_clr)          bit_idx_q <= '0;
         else if (sample_data) bit_idx_q <= bit_idx_q + 3'd1;
         valid_q    <= accept;
         if (accept) rx_byte <= shift_q;
         stop_err_q <= stop_fail;
`ifdef UART_PARITY_EN
         par_err_q  <= par_fail;
`endif
      end
   end

   // Data shift register, LSB arrives first
   always_ff @(posedge clk) begin
      if (sample_data) shift_q <= {rxd_s2, shift_q[7:1]};
`ifdef UART_PARITY_EN
      if (sample_par)  par_q   <= rxd_s2;
`endif
   end

   // Status outputs are forced low for the whole time rst is high,
   // including the cycle before the first reset edge.
   assign busy       = (state_q != ST_IDLE) && !rst;
   assign byte_valid = valid_q && !rst;
   assign stop_err   = stop_err_q && !rst;
`ifdef UART_PARITY_EN
   assign parity_err = par_err_q && !rst;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/uart_img_loader.sv
// -----------------------------------------------------------------------------
// uart_img_loader
// Receives 8-bit gray pixels over UART and emits one write strobe per pixel
// with a raster address that wraps after IMG_W*IMG_H pixels.
// Optional feature macro: UART_PARITY_EN (even parity, 8E1 framing).
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   uart_rxd   in   asynchronous serial line, idle high
//   wr_en      out  one-cycle pixel write strobe
//   wr_addr    out  pixel address, clog2(IMG_W*IMG_H) bits
//   wr_data    out  received pixel, held between writes
//   frame_done out  pulses with the write of the last pixel of a frame
//   stop_err   out  pulses when a byte is dropped for a low stop bit
//   parity_err out  pulses when a byte is dropped for bad parity
//   busy       out  receiver is outside IDLE
// -----------------------------------------------------------------------------
module uart_img_loader
   import uart_img_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int UART_BPS = 115200,
   parameter int IMG_W    = 64,
   parameter int IMG_H    = 64
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  uart_rxd,
   output logic                                  wr_en,
   output logic [calc_addr_w(IMG_W*IMG_H)-1:0]   wr_addr,
   output logic [7:0]                            wr_data,
   output logic                                  frame_done,
   output logic                                  stop_err,
   output logic                                  parity_err,
   output logic                                  busy
);

   localparam int                ADDR_W    = calc_addr_w(IMG_W * IMG_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

   logic byte_valid;

   uart_rx_byte #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .uart_rxd   (uart_rxd),
      .busy       (busy),
      .byte_valid (byte_valid),
      .rx_byte    (wr_data),
      .stop_err   (stop_err),
      .parity_err (parity_err)
   );

   assign wr_en      = byte_valid;
   assign frame_done = byte_valid && (wr_addr == LAST_ADDR);

   // Address advances the cycle after each write and wraps after the frame.
   always_ff @(posedge clk) begin
      if (rst)             wr_addr <= '0;
      else if (byte_valid) wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
   end

endmodule

// File: tb/tb_uart_img_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_img_loader
// Directed bench: dut0 uses default parameters (434 clocks per bit, 64x64),
// dut1 is a 4x4 image at 10 clocks per bit for the frame-wrap sequence.
// Build with UART_PARITY_EN defined to exercise the parity path.
// -----------------------------------------------------------------------------
module tb_uart_img_loader;

   localparam int BAUD0 = 50000000 / 115200;
   localparam int HALF0 = BAUD0 / 2;
`ifdef UART_PARITY_EN
   localparam int LAT0  = HALF0 + 3 + 10 * BAUD0;
`else
   localparam int LAT0  = HALF0 + 3 + 9 * BAUD0;
`endif
   localparam int BAUD1 = 1000000 / 100000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd0 = 1'b1;
   logic rxd1 = 1'b1;

   always #5 clk = ~clk;

   logic        wr_en0, frame_done0, stop_err0, parity_err0, busy0;
   logic [11:0] wr_addr0;
   logic [7:0]  wr_data0;
   logic        wr_en1, frame_done1, stop_err1, parity_err1, busy1;
   logic [3:0]  wr_addr1;
   logic [7:0]  wr_data1;

   uart_img_loader dut0 (
      .clk(clk), .rst(rst), .uart_rxd(rxd0),
      .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
      .frame_done(frame_done0), .stop_err(stop_err0),
      .parity_err(parity_err0), .busy(busy0)
   );

   uart_img_loader #(
      .CLK_FREQ(1000000), .UART_BPS(100000), .IMG_W(4), .IMG_H(4)
   ) dut1 (
      .clk(clk), .rst(rst), .uart_rxd(rxd1),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .frame_done(frame_done1), .stop_err(stop_err1),
      .parity_err(parity_err1), .busy(busy1)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int start_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write monitors and strobe-width watch
   int wa0[$], wd0[$], wc0[$];
   int wa1[$], wd1[$], wf1[$];
   int n_stop0 = 0, n_par0 = 0, n_fd1 = 0, viol = 0;
   logic [3:0] prv0 = '0, prv1 = '0;

   always @(negedge clk) begin
      if (wr_en0) begin
         wa0.push_back(int'(wr_addr0));
         wd0.push_back(int'(wr_data0));
         wc0.push_back(cyc);
      end
      if (wr_en1) begin
         wa1.push_back(int'(wr_addr1));
         wd1.push_back(int'(wr_data1));
         wf1.push_back(int'(frame_done1));
      end
      if (stop_err0)   n_stop0++;
      if (parity_err0) n_par0++;
      if (frame_done1) n_fd1++;
      if (({wr_en0, frame_done0, stop_err0, parity_err0} & prv0) != 4'd0) viol++;
      if (({wr_en1, frame_done1, stop_err1, parity_err1} & prv1) != 4'd0) viol++;
      prv0 = {wr_en0, frame_done0, stop_err0, parity_err0};
      prv1 = {wr_en1, frame_done1, stop_err1, parity_err1};
   end

   task automatic set_line(input int ln, input logic v);
      if (ln == 0) rxd0 = v;
      else         rxd1 = v;
   endtask

   // Drives one frame starting at the current negedge. par_good selects a
   // correct or inverted even-parity bit (parity builds only). The line is
   // left at the stop-bit level.
   task automatic send_frame(input int ln, input int b, input logic [7:0] d,
                             input logic par_good, input logic stop_b);
      start_cyc = cyc;
      set_line(ln, 1'b0);
      repeat (b) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_line(ln, d[i]);
         repeat (b) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      set_line(ln, (^d) ^ !par_good);
      repeat (b) @(negedge clk);
`endif
      set_line(ln, stop_b);
      repeat (b) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_wr_en"},      wr_en0,      0);
      chk({pfx, "_wr_addr"},    wr_addr0,    0);
      chk({pfx, "_wr_data"},    wr_data0,    0);
      chk({pfx, "_busy"},       busy0,       0);
      chk({pfx, "_stop_err"},   stop_err0,   0);
      chk({pfx, "_parity_err"}, parity_err0, 0);
      chk({pfx, "_frame_done"}, frame_done0, 0);
   endtask

   initial begin
      int n;
      logic [7:0] pat;

      // Reset state
      repeat (4) @(negedge clk);
      chk_all_zero("rst");
      rst = 1'b0;
      @(negedge clk);

      // 4x4 frame: 16 back-to-back bytes then one more that wraps to 0
      for (int i = 0; i < 16; i++) send_frame(1, BAUD1, 8'(i), 1'b1, 1'b1);
      send_frame(1, BAUD1, 8'h20, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      chk("frm_nwr", wa1.size(), 17);
      for (int i = 0; i < 17; i++) begin
         if (i < wa1.size()) begin
            chk($sformatf("frm_addr%0d", i), wa1[i], (i < 16) ? i : 0);
            chk($sformatf("frm_data%0d", i), wd1[i], (i < 16) ? i : 32'h20);
            chk($sformatf("frm_fd%0d", i),   wf1[i], (i == 15) ? 1 : 0);
         end
      end
      chk("frm_fd_count", n_fd1, 1);

      // Single byte 0xA5 at default rate, including write latency
      send_frame(0, BAUD0, 8'hA5, 1'b1, 1'b1);
      n = start_cyc;
      repeat (10) @(negedge clk);
      chk("a5_nwr", wa0.size(), 1);
      if (wa0.size() >= 1) begin
         chk("a5_addr", wa0[0], 0);
         chk("a5_data", wd0[0], 32'hA5);
         chk("a5_latency", wc0[0] - n, LAT0);
      end

      // 100-cycle glitch is rejected at the start-bit midpoint
      rxd0 = 1'b0;
      repeat (50) @(negedge clk);
      chk("glitch_busy_hi", busy0, 1);
      repeat (50) @(negedge clk);
      rxd0 = 1'b1;
      repeat (400) @(negedge clk);
      chk("glitch_busy_lo", busy0, 0);
      chk("glitch_nwr", wa0.size(), 1);
      chk("hold_data", wr_data0, 32'hA5);
      send_frame(0, BAUD0, 8'h3C, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      chk("3c_nwr", wa0.size(), 2);
      if (wa0.size() >= 2) begin
         chk("3c_addr", wa0[1], 1);
         chk("3c_data", wd0[1], 32'h3C);
      end

      // Low stop bit followed by a long break
      send_frame(0, BAUD0, 8'h55, 1'b1, 1'b0);
      repeat (1000) @(negedge clk);
      chk("brk_busy", busy0, 1);
      chk("brk_stop_err", n_stop0, 1);
      repeat (1000) @(negedge clk);
      rxd0 = 1'b1;
      repeat (20) @(negedge clk);
      chk("brk_busy_lo", busy0, 0);
      chk("brk_nwr", wa0.size(), 2);
      chk("brk_addr", wr_addr0, 2);
      send_frame(0, BAUD0, 8'h81, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      chk("81_nwr", wa0.size(), 3);
      if (wa0.size() >= 3) begin
         chk("81_addr", wa0[2], 2);
         chk("81_data", wd0[2], 32'h81);
      end
      chk("stop_err_total", n_stop0, 1);

`ifdef UART_PARITY_EN
      // 0x07 has three ones: parity bit 0 is wrong, 1 is right
      send_frame(0, BAUD0, 8'h07, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      chk("par_bad_err", n_par0, 1);
      chk("par_bad_nwr", wa0.size(), 3);
      chk("par_bad_addr", wr_addr0, 3);
      send_frame(0, BAUD0, 8'h07, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      chk("par_ok_nwr", wa0.size(), 4);
      if (wa0.size() >= 4) begin
         chk("par_ok_addr", wa0[3], 3);
         chk("par_ok_data", wd0[3], 32'h07);
      end
      chk("par_err_total", n_par0, 1);
`else
      chk("par_err_tied", n_par0, 0);
`endif

      // Reset in the middle of data bit 4
      n = wa0.size();
      pat = 8'hC3;
      rxd0 = 1'b0;
      repeat (BAUD0) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd0 = pat[i];
         repeat (BAUD0) @(negedge clk);
      end
      rxd0 = pat[4];
      repeat (BAUD0 / 2) @(negedge clk);
      chk("mid_busy", busy0, 1);
      rst  = 1'b1;
      rxd0 = 1'b1;
      repeat (4) @(negedge clk);
      chk_all_zero("in_rst");
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("post_rst");
      repeat (2 * BAUD0) @(negedge clk);
      chk("rst_nwr", wa0.size(), n);
      send_frame(0, BAUD0, 8'h5A, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      chk("5a_nwr", wa0.size(), n + 1);
      if (wa0.size() >= n + 1) begin
         chk("5a_addr", wa0[n], 0);
         chk("5a_data", wd0[n], 32'h5A);
      end

      chk("strobe_one_cycle", viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_img_loader.md
UART_IMG_LOADER -- requirements
Module: uart_img_loader

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter UART_BPS, default 115200, serial bit rate.
REQ-003 The block SHALL have parameter IMG_W, default 64, image width in pixels.
REQ-004 The block SHALL have parameter IMG_H, default 64, image height in pixels.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port uart_rxd, input, 1 bit, asynchronous serial line, idle high.
REQ-008 The block SHALL have port wr_en, output, 1 bit, one-cycle pixel-write strobe.
REQ-009 The block SHALL have port wr_addr, output, ADDR_W = clog2(IMG_W*IMG_H) bits, pixel address.
REQ-010 The block SHALL have port wr_data, output, 8 bits, received gray pixel.
REQ-011 The block SHALL have port frame_done, output, 1 bit, one-cycle pulse when the last pixel is written.
REQ-012 The block SHALL have port stop_err, output, 1 bit, one-cycle pulse when a byte is rejected for a low stop bit.
REQ-013 The block SHALL have port parity_err, output, 1 bit, one-cycle pulse when a byte is rejected for bad parity.
REQ-014 The block SHALL have port busy, output, 1 bit, high while any state other than IDLE is active.

Function
REQ-015 uart_rxd SHALL pass through a 2-flop synchronizer whose flops reset to 1.
REQ-016 BAUD_CNT SHALL equal CLK_FREQ/UART_BPS (integer division); HALF SHALL equal BAUD_CNT/2.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY (present only when parity is compiled in), STOP and BREAK.
REQ-018 In IDLE, a high-to-low transition of the synchronized line SHALL move the FSM to START and clear the baud counter.
REQ-019 In START, after HALF cycles, a sampled low SHALL go to DATA; a sampled high SHALL be treated as a glitch and return to IDLE with no outputs asserted.
REQ-020 In DATA, 8 bits SHALL be sampled LSB first, each BAUD_CNT cycles after the previous sample, then the FSM SHALL go to PARITY if present, else to STOP.
REQ-021 STOP SHALL sample BAUD_CNT cycles after the last sample; on high, wr_en, wr_data and wr_addr SHALL be valid on the following cycle, and the FSM SHALL go to IDLE so back-to-back frames are accepted.
REQ-022 On a low stop bit, stop_err SHALL pulse, no write SHALL occur, wr_addr SHALL be unchanged, and the FSM SHALL go to BREAK.
REQ-023 BREAK SHALL wait until the synchronized line is high, then go to IDLE.
REQ-024 wr_addr SHALL increment by 1 on the cycle after each write; the write at address IMG_W*IMG_H-1 SHALL pulse frame_done in the same cycle as wr_en, and wr_addr SHALL then wrap to 0.
REQ-025 wr_data SHALL hold the last written byte between writes.
REQ-026 wr_en, frame_done, stop_err and parity_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-027 While rst is high, the FSM SHALL be in IDLE and the counters SHALL be 0.
REQ-028 While rst is high, wr_en, frame_done, stop_err, parity_err and busy SHALL be 0, and wr_addr and wr_data SHALL be 0.
REQ-029 Reset asserted mid-byte SHALL discard the partial byte.
REQ-030 After reset is released, the block SHALL be ready for a new start bit on the next cycle.

Configuration
REQ-031 With UART_PARITY_EN defined, the PARITY state SHALL sample one even-parity bit after the data bits.
REQ-032 With UART_PARITY_EN defined, a parity mismatch SHALL still sample the stop bit, then pulse parity_err, suppress the write and leave wr_addr unchanged.
REQ-033 Without UART_PARITY_EN, the format SHALL be 8N1, the PARITY state SHALL be absent, and parity_err SHALL be tied to 0.

Structure
REQ-034 Package uart_img_pkg SHALL hold the FSM state enum, the BAUD_CNT and HALF calculation functions, and the ADDR_W derivation.
REQ-035 A sub-module uart_rx_byte SHALL contain the synchronizer, FSM and baud counter, and SHALL output byte_valid, byte and the error pulses; the top level SHALL add only the address counter and frame logic.

Verification
REQ-036 Test, default parameters (BAUD_CNT=434): send byte 0xA5 -> wr_en pulses once with wr_data=0xA5 and wr_addr=0, one cycle after the mid-stop sample.
REQ-037 Test, IMG_W=IMG_H=4: send 16 bytes 0x00..0x0F back-to-back -> 16 writes at addresses 0..15; frame_done coincides with the write of 0x0F; the next byte is written at address 0.
REQ-038 Test: drive a 100-cycle low glitch on uart_rxd -> no wr_en, busy returns low, and a following 0x3C is written correctly.
REQ-039 Test: send 0x55 with the stop bit low and hold the line low for 2000 cycles -> stop_err pulses once, no write occurs, wr_addr stays unchanged, and the next valid byte is accepted after the line goes high.
REQ-040 Test, UART_PARITY_EN defined: send 0x07 with parity bit 0 -> parity_err pulses once and no write occurs; send 0x07 with parity bit 1 -> written.
REQ-041 Test: assert rst during data bit 4 of a byte -> no write occurs, and all outputs are 0 on the cycle after reset.
